bus_transfer_scheduler: RTL and testbench

Queues register-to-register bus transfer requests and drives the datapath bus controls for each transfer in turn. For each queued transfer it asserts one one-hot source-enable line into the bus source encoder, then pulses the one-hot destination load enable. Sources are ordered as in the bus select map: 0–15 R0–R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 In_Port, 23 C. It sits between the control unit, which issues requests, and the bus/register-file enables.

---
 rtl/bus_transfer_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_bus_transfer_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_scheduler.sv
// bus_transfer_scheduler: queues register-to-register transfer requests and
// sequences the one-hot bus source enable and destination load enable for
// each one. Each transfer takes two cycles: DRIVE puts the source on the bus,
// LATCH keeps the source driven and pulses the destination load.
//
// Request handshake: a request transfers when req_valid_i && req_ready_o at a
// rising edge of clock_i. req_ready_o comes only from the registered fill
// count, so it never depends on a pop at the same edge. Invalid requests are
// still handshaked (then dropped and flagged on err_o), so the requester never
// stalls on a bad code.
module bus_transfer_scheduler #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock_i,
    input  logic          clear_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [4:0]    req_src_i,
    input  logic [4:0]    req_dst_i,
    input  logic          flush_i,
    output logic [23:0]   src_en_o,
    output logic [23:0]   dst_ld_o,
    output logic          done_o,
    output logic          err_o,
    output logic          busy_o,
    output logic [CW-1:0] fill_count_o,
    output logic [1:0]    state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [23:0] ONE_HOT_BASE = 24'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    cur_src_q, cur_src_d;
    logic [4:0]    cur_dst_q, cur_dst_d;
    logic [23:0]   src_en_q, src_en_d;
    logic [23:0]   dst_ld_q, dst_ld_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // Each FIFO entry holds {src, dst}.
    logic [9:0]    fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          handshake;
    logic          src_ok;
    logic          dst_ok;
    logic          push;
    logic          pop;

    // Z, In_Port and C cannot be loaded from the bus; codes above 23 do not exist.
    assign src_ok    = (req_src_i <= 5'd23);
    assign dst_ok    = (req_dst_i <= 5'd17) || (req_dst_i == 5'd20) || (req_dst_i == 5'd21);
    assign handshake = req_valid_i && req_ready_o;
    assign push      = handshake && src_ok && dst_ok && !flush_i;

    // Next state, pop decision and the registered bus controls for the next cycle.
    always_comb begin
        state_d   = state_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        pop       = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        pop                    = 1'b1;
                        {cur_src_d, cur_dst_d} = fifo_q[rd_ptr_q];
                        state_d                = DRIVE;
                    end
                end
                DRIVE: begin
                    state_d = LATCH;
                end
                LATCH: begin
                    if (count_q != '0) begin
                        pop                    = 1'b1;
                        {cur_src_d, cur_dst_d} = fifo_q[rd_ptr_q];
                        state_d                = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        src_en_d = '0;
        dst_ld_d = '0;
        done_d   = 1'b0;
        if (state_d != IDLE) begin
            src_en_d = ONE_HOT_BASE << cur_src_d;
        end
        if (state_d == LATCH) begin
            dst_ld_d = ONE_HOT_BASE << cur_dst_d;
            done_d   = 1'b1;
        end

        err_d = handshake && !(src_ok && dst_ok) && !flush_i;
    end

    // FIFO pointer and occupancy bookkeeping; flush empties the queue outright.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers; clear drops everything to idle immediately.
    always_ff @(posedge clock_i or posedge clear_i) begin
        if (clear_i) begin
            state_q   <= IDLE;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            src_en_q  <= '0;
            dst_ld_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            src_en_q  <= src_en_d;
            dst_ld_q  <= dst_ld_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage; entries are only meaningful below the fill count, so no reset.
    always_ff @(posedge clock_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {req_src_i, req_dst_i};
        end
    end

    assign req_ready_o  = (count_q < FULL_COUNT);
    assign src_en_o     = src_en_q;
    assign dst_ld_o     = dst_ld_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign busy_o       = (state_q != IDLE) || (count_q != '0);
    assign fill_count_o = count_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_bus_transfer_scheduler.sv
// Directed bench for bus_transfer_scheduler: single transfer, invalid codes,
// fill to full with back-to-back execution, FIFO wrap ordering, flush and
// asynchronous clear mid-transfer.
module tb_bus_transfer_scheduler;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  // clock / reset
  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [4:0]    req_src = '0;
  logic [4:0]    req_dst = '0;
  logic          flush = 1'b0;
  logic [23:0]   src_en;
  logic [23:0]   dst_ld;
  logic          done;
  logic          err;
  logic          busy;
  logic [CW-1:0] fill_count;
  logic [1:0]    state;

  always #5 clock = ~clock;

  bus_transfer_scheduler #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clock_i      (clock),
    .clear_i      (clear),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_src_i    (req_src),
    .req_dst_i    (req_dst),
    .flush_i      (flush),
    .src_en_o     (src_en),
    .dst_ld_o     (dst_ld),
    .done_o       (done),
    .err_o        (err),
    .busy_o       (busy),
    .fill_count_o (fill_count),
    .state_o      (state)
  );

  int n_vec = 0;
  int n_err = 0;

  // scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] oh(input int code);
    logic [23:0] base;
    base = 24'd1;
    return base << code;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [4:0] s, input logic [4:0] d);
    req_valid = v;
    req_src   = s;
    req_dst   = d;
  endtask

  function automatic logic [4:0] w_src(input int i);
    return 5'((i * 5) % 24);
  endfunction

  function automatic logic [4:0] w_dst(input int i);
    return 5'(i % 18);
  endfunction

  // scenario tables for fill-to-full: requests R1..R8 and per-edge expectations
  logic [4:0] s2_src [8] = '{5'd1, 5'd3, 5'd16, 5'd20, 5'd23, 5'd22, 5'd7, 5'd9};
  logic [4:0] s2_dst [8] = '{5'd2, 5'd4, 5'd17, 5'd0,  5'd21, 5'd20, 5'd7, 5'd10};
  int s2_act  [16] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 0};
  int s2_lat  [16] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  int s2_fill [16] = '{1, 1, 2, 2, 3, 3, 4, 3, 3, 2, 2, 1, 1, 0, 0, 0};
  int s2_rdy  [16] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] exp_src;
    logic [23:0] exp_dst;
    int pi;
    int dc;
    bit hs;

    // reset state
    #2;
    check_eq("rst_src_en", src_en, 0);
    check_eq("rst_dst_ld", dst_ld, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_fill", fill_count, 0);
    @(posedge clock);
    #1;
    clear = 1'b0;

    // single transfer src=5 dst=16
    drive_req(1'b1, 5'd5, 5'd16);
    tick();
    drive_req(1'b0, 5'd0, 5'd0);
    check_eq("one_push_fill", fill_count, 1);
    check_eq("one_push_src", src_en, 0);
    tick();
    check_eq("one_drive_src", src_en, 24'h000020);
    check_eq("one_drive_dst", dst_ld, 0);
    check_eq("one_drive_done", done, 0);
    check_eq("one_drive_fill", fill_count, 0);
    tick();
    check_eq("one_latch_src", src_en, 24'h000020);
    check_eq("one_latch_dst", dst_ld, 24'h010000);
    check_eq("one_latch_done", done, 1);
    tick();
    check_eq("one_idle_src", src_en, 0);
    check_eq("one_idle_dst", dst_ld, 0);
    check_eq("one_idle_done", done, 0);
    check_eq("one_idle_busy", busy, 0);

    // invalid requests: dst=19, then src=25
    drive_req(1'b1, 5'd3, 5'd19);
    tick();
    drive_req(1'b0, 5'd0, 5'd0);
    check_eq("bad_dst_err", err, 1);
    check_eq("bad_dst_fill", fill_count, 0);
    check_eq("bad_dst_src", src_en, 0);
    tick();
    check_eq("bad_dst_err_gone", err, 0);
    check_eq("bad_dst_src2", src_en, 0);
    drive_req(1'b1, 5'd25, 5'd4);
    tick();
    drive_req(1'b0, 5'd0, 5'd0);
    check_eq("bad_src_err", err, 1);
    check_eq("bad_src_fill", fill_count, 0);
    tick();
    check_eq("bad_src_err_gone", err, 0);
    check_eq("bad_src_src", src_en, 0);
    check_eq("bad_src_busy", busy, 0);

    // fill to full while transfers execute, then drain in order
    for (int i = 0; i < 16; i++) begin
      if (i <= 7) drive_req(1'b1, s2_src[i], s2_dst[i]);
      else drive_req(1'b0, 5'd0, 5'd0);
      tick();
      exp_src = (s2_act[i] == 0) ? 24'd0 : oh(int'(s2_src[s2_act[i] - 1]));
      exp_dst = (s2_lat[i] == 0) ? 24'd0 : oh(int'(s2_dst[s2_act[i] - 1]));
      check_eq($sformatf("full_src_e%0d", i), src_en, exp_src);
      check_eq($sformatf("full_dst_e%0d", i), dst_ld, exp_dst);
      check_eq($sformatf("full_done_e%0d", i), done, s2_lat[i]);
      check_eq($sformatf("full_fill_e%0d", i), fill_count, s2_fill[i]);
      check_eq($sformatf("full_rdy_e%0d", i), req_ready, s2_rdy[i]);
    end
    check_eq("full_end_busy", busy, 0);

    // FIFO wrap over 10 transfers, order checked on each done
    pi = 0;
    dc = 0;
    for (int cyc = 0; cyc < 200 && dc < 10; cyc++) begin
      if (pi < 10) drive_req(1'b1, w_src(pi), w_dst(pi));
      else drive_req(1'b0, 5'd0, 5'd0);
      hs = req_valid && req_ready;
      tick();
      if (hs) pi++;
      if (done) begin
        check_eq($sformatf("wrap_src_%0d", dc), src_en, oh(int'(w_src(dc))));
        check_eq($sformatf("wrap_dst_%0d", dc), dst_ld, oh(int'(w_dst(dc))));
        dc++;
      end
    end
    drive_req(1'b0, 5'd0, 5'd0);
    check_eq("wrap_count", dc, 10);
    tick();
    check_eq("wrap_end_busy", busy, 0);
    check_eq("wrap_end_fill", fill_count, 0);

    // flush during DRIVE with 3 entries queued, invalid request on the flush edge
    for (int i = 0; i < 6; i++) begin
      drive_req(1'b1, s2_src[i], s2_dst[i]);
      tick();
    end
    check_eq("fl_pre_src", src_en, oh(16));
    check_eq("fl_pre_dst", dst_ld, 0);
    check_eq("fl_pre_fill", fill_count, 3);
    flush = 1'b1;
    drive_req(1'b1, 5'd3, 5'd22);
    tick();
    flush = 1'b0;
    drive_req(1'b0, 5'd0, 5'd0);
    check_eq("fl_src", src_en, 0);
    check_eq("fl_dst", dst_ld, 0);
    check_eq("fl_done", done, 0);
    check_eq("fl_fill", fill_count, 0);
    check_eq("fl_busy", busy, 0);
    check_eq("fl_err", err, 0);
    check_eq("fl_ready", req_ready, 1);
    tick();
    check_eq("fl_after_done", done, 0);
    check_eq("fl_after_src", src_en, 0);
    tick();
    check_eq("fl_after2_done", done, 0);

    // asynchronous clear mid-LATCH
    drive_req(1'b1, 5'd2, 5'd3);
    tick();
    drive_req(1'b1, 5'd4, 5'd5);
    tick();
    drive_req(1'b0, 5'd0, 5'd0);
    tick();
    check_eq("clr_pre_dst", dst_ld, oh(3));
    check_eq("clr_pre_done", done, 1);
    check_eq("clr_pre_fill", fill_count, 1);
    #2;
    clear = 1'b1;
    #1;
    check_eq("clr_src", src_en, 0);
    check_eq("clr_dst", dst_ld, 0);
    check_eq("clr_done", done, 0);
    check_eq("clr_busy", busy, 0);
    check_eq("clr_fill", fill_count, 0);
    check_eq("clr_ready", req_ready, 1);
    @(posedge clock);
    #3;
    clear = 1'b0;
    drive_req(1'b1, 5'd20, 5'd21);
    tick();
    drive_req(1'b0, 5'd0, 5'd0);
    check_eq("post_push_fill", fill_count, 1);
    tick();
    check_eq("post_drive_src", src_en, oh(20));
    check_eq("post_drive_dst", dst_ld, 0);
    tick();
    check_eq("post_latch_src", src_en, oh(20));
    check_eq("post_latch_dst", dst_ld, oh(21));
    check_eq("post_latch_done", done, 1);
    tick();
    check_eq("post_idle_src", src_en, 0);
    check_eq("post_idle_busy", busy, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
